// File: rtl/sigma_delta_modulator_2nd.sv
// Second-order sigma-delta modulator: signed PCM in, registered 1-bit stream out, one bit every DIV clocks.
// A sample accepted into the one-deep holding register reaches bit_out within two ticks; sample_ready is low while that register is full.
module sigma_delta_modulator_2nd #(
  parameter int INPUT_WIDTH = 24,
  parameter int ACC_WIDTH   = 28,
  parameter int DIV         = 10
) (
  input  logic                          clock_200,
  input  logic                          reset,
  input  logic                          enable,
  input  logic signed [INPUT_WIDTH-1:0] sample_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic                          bit_out,
  output logic                          bit_valid,
  output logic                          overflow,
  input  logic                          clear_overflow
);

  localparam int SUM_W = ACC_WIDTH + 2;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

  localparam logic signed [SUM_W-1:0] ACC_MAX = {3'b000, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] ACC_MIN = {3'b111, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] FB_POS  = {{(SUM_W-INPUT_WIDTH+1){1'b0}}, {(INPUT_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] FB_NEG  = {{(SUM_W-INPUT_WIDTH+1){1'b1}}, {(INPUT_WIDTH-1){1'b0}}};

  logic [CNT_W-1:0]              div_cnt_q, div_cnt_d;
  logic signed [ACC_WIDTH-1:0]   int1_q, int1_d;
  logic signed [ACC_WIDTH-1:0]   int2_q, int2_d;
  logic signed [INPUT_WIDTH-1:0] current_q, current_d;
  logic signed [INPUT_WIDTH-1:0] pending_q, pending_d;
  logic                          pending_full_q, pending_full_d;
  logic                          bit_out_q, bit_out_d;
  logic                          bit_valid_q, bit_valid_d;
  logic                          overflow_q, overflow_d;

  logic                          tick;
  logic                          accept;
  logic signed [SUM_W-1:0]       fb;
  logic signed [SUM_W-1:0]       sum1;
  logic signed [SUM_W-1:0]       sum2;
  logic signed [ACC_WIDTH-1:0]   int1_n;
  logic signed [ACC_WIDTH-1:0]   int2_n;
  logic                          clamp1;
  logic                          clamp2;

  assign sample_ready = !pending_full_q && !reset;

  always_comb begin
    tick   = enable && (div_cnt_q == DIV_LAST);
    accept = sample_valid && !pending_full_q && !reset;
    fb     = bit_out_q ? FB_POS : FB_NEG;

    // Sums carry two guard bits so the clamp sees the true value before truncation.
    sum1   = {{2{int1_q[ACC_WIDTH-1]}}, int1_q}
           + {{(SUM_W-INPUT_WIDTH){current_q[INPUT_WIDTH-1]}}, current_q}
           - fb;
    clamp1 = (sum1 > ACC_MAX) || (sum1 < ACC_MIN);
    if (sum1 > ACC_MAX)      int1_n = ACC_MAX[ACC_WIDTH-1:0];
    else if (sum1 < ACC_MIN) int1_n = ACC_MIN[ACC_WIDTH-1:0];
    else                     int1_n = sum1[ACC_WIDTH-1:0];

    sum2   = {{2{int2_q[ACC_WIDTH-1]}}, int2_q}
           + {{2{int1_n[ACC_WIDTH-1]}}, int1_n}
           - fb;
    clamp2 = (sum2 > ACC_MAX) || (sum2 < ACC_MIN);
    if (sum2 > ACC_MAX)      int2_n = ACC_MAX[ACC_WIDTH-1:0];
    else if (sum2 < ACC_MIN) int2_n = ACC_MIN[ACC_WIDTH-1:0];
    else                     int2_n = sum2[ACC_WIDTH-1:0];

    div_cnt_d      = div_cnt_q;
    int1_d         = int1_q;
    int2_d         = int2_q;
    current_d      = current_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    bit_out_d      = bit_out_q;
    bit_valid_d    = tick;
    overflow_d     = overflow_q;

    if (enable) begin
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    end

    if (tick) begin
      int1_d    = int1_n;
      int2_d    = int2_n;
      bit_out_d = !int2_n[ACC_WIDTH-1];
      if (pending_full_q) begin
        current_d      = pending_q;
        pending_full_d = 1'b0;
      end
    end

    // accept only happens with pending empty, so it never races the transfer above
    if (accept) begin
      pending_d      = sample_in;
      pending_full_d = 1'b1;
    end

    if (tick && (clamp1 || clamp2)) overflow_d = 1'b1;
    else if (clear_overflow)        overflow_d = 1'b0;
  end

  always_ff @(posedge clock_200) begin
    if (reset) begin
      div_cnt_q      <= '0;
      int1_q         <= '0;
      int2_q         <= '0;
      current_q      <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      bit_out_q      <= 1'b0;
      bit_valid_q    <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      div_cnt_q      <= div_cnt_d;
      int1_q         <= int1_d;
      int2_q         <= int2_d;
      current_q      <= current_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      bit_out_q      <= bit_out_d;
      bit_valid_q    <= bit_valid_d;
      overflow_q     <= overflow_d;
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign overflow  = overflow_q;

endmodule
